// File: rtl/commit_stage_if.sv
// commit_stage_if: execute-to-commit bundle plus writeback, CSR and trap outputs of the commit stage.
interface commit_stage_if;
    logic        valid5;
    logic [4:0]  rd5;
    logic        we5;
    logic [1:0]  wb_sel5;
    logic [31:0] alu_res5;
    logic [31:0] csr_res5;
    logic [31:0] pc5;
    logic        csr_we5;
    logic [11:0] csr_addr5;
    logic [31:0] csr_wdata5;
    logic        misaligned5;
    logic        illegal5;
    logic        ecall5;
    logic        mret5;
    logic        sret5;
    logic        uret5;
    logic [1:0]  current_mode;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        we6;
    logic [4:0]  rdaddr6;
    logic [31:0] wb6;
    logic        csr_we6;
    logic [11:0] csr_wb_addr;
    logic [31:0] csr_wb;
    logic        exception_pending;
    logic [31:0] cause;
    logic [31:0] pc_exc;
    logic        m_ret;
    logic        s_ret;
    logic        u_ret;
    logic        exception;
    logic        stall_commit;

    modport master (
        output valid5, rd5, we5, wb_sel5, alu_res5, csr_res5, pc5, csr_we5, csr_addr5, csr_wdata5,
               misaligned5, illegal5, ecall5, mret5, sret5, uret5, current_mode, mem_rvalid, mem_rdata,
        input  we6, rdaddr6, wb6, csr_we6, csr_wb_addr, csr_wb, exception_pending, cause, pc_exc,
               m_ret, s_ret, u_ret, exception, stall_commit
    );

    modport slave (
        input  valid5, rd5, we5, wb_sel5, alu_res5, csr_res5, pc5, csr_we5, csr_addr5, csr_wdata5,
               misaligned5, illegal5, ecall5, mret5, sret5, uret5, current_mode, mem_rvalid, mem_rdata,
        output we6, rdaddr6, wb6, csr_we6, csr_wb_addr, csr_wb, exception_pending, cause, pc_exc,
               m_ret, s_ret, u_ret, exception, stall_commit
    );
endinterface

// File: rtl/commit_stage.sv
// commit_stage: retires execute results, selects GPR/CSR writeback, pulses traps/xRETs and squashes younger slots.
module commit_stage #(
    parameter int FLUSH_CYCLES = 2
) (
    input logic           clk,
    input logic           nrst,
    commit_stage_if.slave bus
);
    typedef enum logic [1:0] {RUN, WAIT_MEM, FLUSH} state_t;
    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_wb;
        logic        exc_pend;
        logic [31:0] cause;
        logic [31:0] pc_exc;
        logic        m_ret;
        logic        s_ret;
        logic        u_ret;
        logic        exception;
    } out_t;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [4:0]  ld_rd, ld_rd_nx;
    logic        ld_we, ld_we_nx;
    out_t        out_q, out_d;
    logic        trap, xret;
    logic [31:0] res;

    assign trap = bus.misaligned5 | bus.illegal5 | bus.ecall5;
    assign xret = bus.mret5 | bus.sret5 | bus.uret5;
    assign res  = bus.wb_sel5 == 2'b00 ? bus.alu_res5 :
                  bus.wb_sel5 == 2'b10 ? bus.csr_res5 : bus.pc5 + 32'd4;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ld_rd_nx = ld_rd;
        ld_we_nx = ld_we;
        out_d    = '0;
        case (state)
            RUN: if (bus.valid5) begin
                if (trap | xret) begin
                    state_nx        = FLUSH;
                    cnt_nx          = 3'(FLUSH_CYCLES);
                    out_d.exception = 1'b1;
                    out_d.exc_pend  = trap;
                    out_d.pc_exc    = trap ? bus.pc5 : 32'd0;
                    // ecall cause is 8 + privilege mode (U=8, S=9, M=11)
                    out_d.cause     = !trap ? 32'd0 : bus.misaligned5 ? 32'd0 :
                                      bus.illegal5 ? 32'd2 : {28'd0, 2'b10, bus.current_mode};
                    out_d.m_ret     = !trap & bus.mret5;
                    out_d.s_ret     = !trap & bus.sret5;
                    out_d.u_ret     = !trap & bus.uret5;
                end else if (bus.wb_sel5 == 2'b01) begin
                    state_nx = WAIT_MEM;
                    ld_rd_nx = bus.rd5;
                    ld_we_nx = bus.we5;
                end else begin
                    out_d.we       = bus.we5 & |bus.rd5;
                    out_d.rd       = bus.rd5;
                    out_d.wb       = res;
                    out_d.csr_we   = bus.csr_we5;
                    out_d.csr_addr = bus.csr_addr5;
                    out_d.csr_wb   = bus.csr_wdata5;
                end
            end
            WAIT_MEM: if (bus.mem_rvalid) begin
                state_nx = RUN;
                out_d.we = ld_we & |ld_rd;
                out_d.rd = ld_rd;
                out_d.wb = bus.mem_rdata;
            end
            FLUSH: begin
                cnt_nx   = cnt - 3'd1;
                state_nx = cnt <= 3'd1 ? RUN : FLUSH;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RUN;
            cnt   <= '0;
            ld_rd <= '0;
            ld_we <= 1'b0;
            out_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ld_rd <= ld_rd_nx;
            ld_we <= ld_we_nx;
            out_q <= out_d;
        end
    end

    assign bus.we6               = out_q.we;
    assign bus.rdaddr6           = out_q.rd;
    assign bus.wb6               = out_q.wb;
    assign bus.csr_we6           = out_q.csr_we;
    assign bus.csr_wb_addr       = out_q.csr_addr;
    assign bus.csr_wb            = out_q.csr_wb;
    assign bus.exception_pending = out_q.exc_pend;
    assign bus.cause             = out_q.cause;
    assign bus.pc_exc            = out_q.pc_exc;
    assign bus.m_ret             = out_q.m_ret;
    assign bus.s_ret             = out_q.s_ret;
    assign bus.u_ret             = out_q.u_ret;
    assign bus.exception         = out_q.exception;
    assign bus.stall_commit      = state == WAIT_MEM;
endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: directed stimulus with a scoreboard of expected commit-stage output pulses.
module tb_commit_stage;
    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_wb;
        logic        exc_pend;
        logic [31:0] cause;
        logic [31:0] pc_exc;
        logic        m_ret;
        logic        s_ret;
        logic        u_ret;
        logic        exception;
    } out_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    out_t q[$];
    out_t obs, exp_o;

    commit_stage_if bus();
    commit_stage #(.FLUSH_CYCLES(2)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    always #5 clk = ~clk;

    function automatic out_t cur();
        return '{bus.we6, bus.rdaddr6, bus.wb6, bus.csr_we6, bus.csr_wb_addr, bus.csr_wb,
                 bus.exception_pending, bus.cause, bus.pc_exc, bus.m_ret, bus.s_ret, bus.u_ret, bus.exception};
    endfunction

    function automatic out_t wr(logic we, logic [4:0] rd, logic [31:0] wb);
        out_t o = '0;
        o.we = we; o.rd = rd; o.wb = wb;
        return o;
    endfunction

    function automatic out_t trp(logic [31:0] cause, logic [31:0] pc);
        out_t o = '0;
        o.exc_pend = 1'b1; o.exception = 1'b1; o.cause = cause; o.pc_exc = pc;
        return o;
    endfunction

    function automatic out_t xr(logic m, logic s, logic u);
        out_t o = '0;
        o.m_ret = m; o.s_ret = s; o.u_ret = u; o.exception = 1'b1;
        return o;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_o(string tag, out_t got, out_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid5 = 0; bus.rd5 = 0; bus.we5 = 0; bus.wb_sel5 = 0; bus.alu_res5 = 0; bus.csr_res5 = 0;
        bus.pc5 = 0; bus.csr_we5 = 0; bus.csr_addr5 = 0; bus.csr_wdata5 = 0; bus.misaligned5 = 0;
        bus.illegal5 = 0; bus.ecall5 = 0; bus.mret5 = 0; bus.sret5 = 0; bus.uret5 = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
    endtask

    task automatic alu(logic [4:0] rd, logic [31:0] val, bit push);
        idle();
        bus.valid5 = 1; bus.rd5 = rd; bus.we5 = 1; bus.alu_res5 = val;
        if (push) q.push_back(wr(rd != 0, rd, val));
    endtask

    // Every non-idle output cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nrst) begin
            obs = cur();
            if (obs !== '0) begin
                exp_o = '0;
                if (q.size() != 0) exp_o = q.pop_front();
                chk_o("commit_out", obs, exp_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        bus.current_mode = 2'b11;
        #12;
        chk_o("reset_outputs", cur(), '0);
        chk("reset_stall", 32'(bus.stall_commit), 0);
        @(negedge clk);
        nrst = 1;
        tick();
        alu(5, 32'h1234, 1);
        tick();
        chk("alu_we", 32'(bus.we6), 1);
        chk("alu_wb", bus.wb6, 32'h1234);
        idle();
        tick();
        chk("alu_one_cycle", 32'(bus.we6), 0);
        alu(0, 32'h55, 1);
        tick();
        chk("x0_no_we", 32'(bus.we6), 0);
        for (int i = 1; i <= 3; i++) begin
            alu(5'(i), 32'(i * 16), 1);
            tick();
            chk("b2b_rd", 32'(bus.rdaddr6), 32'(i));
        end
        idle();
        bus.valid5 = 1; bus.wb_sel5 = 2'b01; bus.rd5 = 7; bus.we5 = 1;
        q.push_back(wr(1, 7, 32'hDEADBEEF));
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("load_stall", 32'(bus.stall_commit), 1);
            chk("load_no_early_we", 32'(bus.we6), 0);
            if (i == 1) alu(9, 32'h99, 0);
            if (i == 2) begin
                idle();
                bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        idle();
        chk("load_stall_fall", 32'(bus.stall_commit), 0);
        chk("load_we", 32'(bus.we6), 1);
        chk("load_wb", bus.wb6, 32'hDEADBEEF);
        idle();
        bus.valid5 = 1; bus.misaligned5 = 1; bus.ecall5 = 1; bus.pc5 = 32'h80; bus.rd5 = 4; bus.we5 = 1;
        q.push_back(trp(0, 32'h80));
        tick();
        chk("trap_pend", 32'(bus.exception_pending), 1);
        chk("trap_no_we", 32'(bus.we6), 0);
        idle();
        tick();
        chk("trap_one_cycle", 32'(bus.exception_pending), 0);
        tick();
        bus.current_mode = 2'b01;
        bus.valid5 = 1; bus.ecall5 = 1; bus.pc5 = 32'h200;
        q.push_back(trp(9, 32'h200));
        tick();
        chk("ecall_s_cause", bus.cause, 9);
        idle();
        tick();
        tick();
        bus.current_mode = 2'b11;
        bus.valid5 = 1; bus.illegal5 = 1; bus.ecall5 = 1; bus.pc5 = 32'h300;
        q.push_back(trp(2, 32'h300));
        tick();
        idle();
        tick();
        tick();
        bus.valid5 = 1; bus.ecall5 = 1; bus.pc5 = 32'h400;
        q.push_back(trp(11, 32'h400));
        tick();
        idle();
        tick();
        tick();
        bus.valid5 = 1; bus.mret5 = 1;
        q.push_back(xr(1, 0, 0));
        tick();
        chk("mret_pulse", 32'(bus.m_ret), 1);
        alu(10, 32'hA0, 0);
        tick();
        alu(11, 32'hB0, 0);
        bus.ecall5 = 1;
        tick();
        chk("flush_no_we", 32'(bus.we6), 0);
        alu(12, 32'hC0, 1);
        tick();
        chk("flush_third_we", 32'(bus.we6), 1);
        chk("flush_third_rd", 32'(bus.rdaddr6), 12);
        idle();
        bus.valid5 = 1; bus.sret5 = 1;
        q.push_back(xr(0, 1, 0));
        tick();
        chk("sret_pulse", 32'(bus.s_ret), 1);
        idle();
        tick();
        tick();
        bus.valid5 = 1; bus.wb_sel5 = 2'b10; bus.rd5 = 3; bus.we5 = 1; bus.csr_res5 = 32'h40;
        bus.csr_we5 = 1; bus.csr_addr5 = 12'h305; bus.csr_wdata5 = 32'h100;
        q.push_back('{1'b1, 5'd3, 32'h40, 1'b1, 12'h305, 32'h100, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        tick();
        chk("csr_we", 32'(bus.csr_we6), 1);
        chk("csr_gpr_we", 32'(bus.we6), 1);
        idle();
        bus.valid5 = 1; bus.wb_sel5 = 2'b11; bus.rd5 = 8; bus.we5 = 1; bus.pc5 = 32'hFFFF_FFFC;
        q.push_back(wr(1, 8, 32'h0));
        tick();
        chk("pc4_wrap", bus.wb6, 0);
        idle();
        bus.valid5 = 1; bus.wb_sel5 = 2'b01; bus.rd5 = 7; bus.we5 = 1;
        tick();
        idle();
        tick();
        chk("rst_pre_stall", 32'(bus.stall_commit), 1);
        #2;
        nrst = 0;
        #1;
        chk("rst_async_stall", 32'(bus.stall_commit), 0);
        @(negedge clk);
        nrst = 1;
        tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111_2222;
        tick();
        chk("rst_load_dropped", 32'(bus.we6), 0);
        alu(6, 32'h66, 1);
        tick();
        chk("rst_next_accept", 32'(bus.we6), 1);
        idle();
        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/commit_stage.md
# commit_stage

Final (stage 6) pipeline stage of the in-order RISC-V core: retires instructions delivered by execute and drives the writeback, CSR-writeback and trap interface consumed by issue. It selects the GPR writeback value, waits for load data, and pulses exception/xRET information to the CSR file. After any trap or xRET it squashes a fixed number of younger slots.

## Interface
- FLUSH_CYCLES, 2, slots dropped after a trap/xRET (1..7)
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- valid5  in  1  execute presents an instruction this cycle
- rd5  in  5  destination register
- we5  in  1  GPR write requested
- wb_sel5  in  2  writeback source: 00 alu_res5, 01 load data, 10 csr_res5, 11 pc5+4
- alu_res5  in  32  ALU/mul-div result
- csr_res5  in  32  old CSR value (rd result of csrr*)
- pc5  in  32  instruction PC
- csr_we5, csr_addr5, csr_wdata5  in  1/12/32  CSR write request
- misaligned5, illegal5, ecall5  in  1 each  exception flags
- mret5, sret5, uret5  in  1 each  xRET flags
- current_mode  in  2  privilege (00 U, 01 S, 11 M)
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data (already sign/zero extended)
- we6, rdaddr6, wb6  out  1/5/32  GPR writeback
- csr_we6, csr_wb_addr, csr_wb  out  1/12/32  CSR writeback
- exception_pending  out  1  trap pulse
- cause  out  32  trap cause (bit31=0)
- pc_exc  out  32  PC of trapping instruction
- m_ret, s_ret, u_ret  out  1 each  xRET pulses
- exception  out  1  flush request to scoreboard (high on trap or xRET)
- stall_commit  out  1  execute must hold its outputs

## Operation
- FSM states: RUN, WAIT_MEM, FLUSH. Reset: RUN, flush counter 0, every output 0.
- All outputs except stall_commit are registered and valid for exactly one cycle after the accepting edge; they return to 0 on the next edge unless another commit occurs.
- RUN, valid5=1, evaluated in priority order:
- misaligned5 -> cause=0; else illegal5 -> cause=2; else ecall5 -> cause=8+current_mode (8/9/11). On any of these: exception_pending=1, exception=1, pc_exc=pc5, no GPR/CSR write, go FLUSH.
- else mret5/sret5/uret5 -> matching x_ret=1, exception=1, no writes, go FLUSH.
- else wb_sel5=01 -> go WAIT_MEM, latch rd5/we5; nothing written yet.
- else commit: we6=we5 & (rd5!=0), rdaddr6=rd5, wb6 per wb_sel5 (pc5+4 wraps modulo 2^32); csr_we6=csr_we5 with csr_wb_addr/csr_wb from csr_addr5/csr_wdata5, in the same cycle as the GPR write.
- RUN, valid5=0 -> no writes, stay RUN.
- WAIT_MEM: stall_commit=1 (combinational from state); valid5 ignored; on mem_rvalid=1 -> we6=latched we & rd!=0, wb6=mem_rdata, go RUN.
- FLUSH: counter loads FLUSH_CYCLES on entry and decrements each cycle; valid5 slots are dropped with no writes, including any exception/xRET flags; counter reaches 0 -> RUN.
- rd=x0 never asserts we6.
- nrst mid-WAIT_MEM or mid-FLUSH: immediate return to RUN; the pending load is discarded; no write.

## Timing
- Non-load commit latency: 1 cycle (accept edge N, outputs high during cycle N+1).
- Load: write appears one cycle after the edge that samples mem_rvalid. mem_rvalid is sampled only in WAIT_MEM, so the earliest write is 2 cycles after accept.
- stall_commit rises in the cycle after load accept and falls in the cycle after mem_rvalid is sampled.
- A trap or xRET at edge N: the pulse is high during cycle N+1; the slots sampled at edges N+1..N+FLUSH_CYCLES are dropped; the next accept is at edge N+FLUSH_CYCLES+1.
- Back-to-back non-load commits: one per cycle, no bubbles.

## Test plan
- ALU commit: valid5, rd5=5, we5, wb_sel5=00, alu_res5=0x1234 -> next cycle we6=1, rdaddr6=5, wb6=0x1234, one cycle only; rd5=0 -> we6=0.
- Load: wb_sel5=01, rd5=7, mem_rvalid 3 cycles later with 0xDEADBEEF -> stall_commit high 3 cycles, then we6=1, wb6=0xDEADBEEF.
- Trap priority: misaligned5 and ecall5 both set, pc5=0x80 -> cause=0, pc_exc=0x80, exception_pending one cycle, we6=0; ecall5 alone in S-mode -> cause=9.
- Flush: mret5 then 3 consecutive ALU instructions (FLUSH_CYCLES=2) -> m_ret pulse; the first two instructions are not written, the third is written.
- CSR: csrrw with csr_addr5=0x305, csr_wdata5=0x100, csr_res5=0x40, rd5=3 -> same cycle csr_we6=1 (0x305, 0x100) and we6=1, wb6=0x40.
- Reset mid-WAIT_MEM, then mem_rvalid -> no we6; FSM is in RUN and accepts the next valid5.
